// File: rtl/alu_rs_pkg.sv
// Shared widths, opcode encodings and CDB tag-match helper for the ALU reservation station.

package alu_rs_pkg;

    localparam int unsigned RS_SZ      = 16;
    localparam int unsigned RS_SZ_LOG  = 4;
    localparam int unsigned ROB_SZ_LOG = 4;
    localparam int unsigned TAG_W      = ROB_SZ_LOG + 1;
    localparam int unsigned OP_W       = 6;

    typedef enum logic [OP_W-1:0] {
        OpNop   = 6'd0,
        OpAdd   = 6'd1,
        OpSub   = 6'd2,
        OpAnd   = 6'd3,
        OpOr    = 6'd4,
        OpXor   = 6'd5,
        OpSll   = 6'd6,
        OpSrl   = 6'd7,
        OpSra   = 6'd8,
        OpSlt   = 6'd9,
        OpSltu  = 6'd10,
        OpBeq   = 6'd11,
        OpBne   = 6'd12,
        OpBlt   = 6'd13,
        OpBge   = 6'd14,
        OpBltu  = 6'd15,
        OpBgeu  = 6'd16,
        OpJal   = 6'd17,
        OpJalr  = 6'd18,
        OpLui   = 6'd19,
        OpAuipc = 6'd20
    } op_e;

    function automatic logic tag_hit(input logic vld, input logic [TAG_W-1:0] tag,
                                     input logic [TAG_W-1:0] q);
        return vld && (tag == q);
    endfunction

endpackage

// File: rtl/alu_rs_prio_sel.sv
// Lowest-index priority encoder returning {found, idx}; used for free-slot and ready-slot picks.

module alu_rs_prio_sel #(
    parameter int unsigned N = 16,
    parameter int unsigned W = 4
) (
    input  logic [N-1:0] req,
    output logic         found,
    output logic [W-1:0] idx
);

    always_comb begin
        found = |req;
        idx   = '0;
        // Scan downwards so the lowest set bit is the last (winning) assignment.
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) idx = W'(i);
        end
    end

endmodule

// File: rtl/alu_rs.sv
// Reservation station for integer/branch/jump ops with two-port CDB capture.
// Optional RS_WAKE_BYPASS_EN lets select consume a same-cycle CDB broadcast directly.

module alu_rs
    import alu_rs_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              clr,
    input  logic              iss_vld,
    input  logic [OP_W-1:0]   iss_op,
    input  logic [TAG_W-1:0]  iss_rd,
    input  logic [31:0]       iss_vj,
    input  logic [31:0]       iss_vk,
    input  logic [TAG_W-1:0]  iss_qj,
    input  logic [TAG_W-1:0]  iss_qk,
    input  logic              iss_qj_b,
    input  logic              iss_qk_b,
    input  logic [31:0]       iss_imm,
    input  logic [31:0]       iss_pc,
    input  logic              cdb_a_vld,
    input  logic [TAG_W-1:0]  cdb_a_tag,
    input  logic [31:0]       cdb_a_val,
    input  logic              cdb_l_vld,
    input  logic [TAG_W-1:0]  cdb_l_tag,
    input  logic [31:0]       cdb_l_val,
    output logic              full,
    output logic              ex_vld,
    output logic [TAG_W-1:0]  ex_rd,
    output logic [31:0]       ex_vj,
    output logic [31:0]       ex_vk,
    output logic [31:0]       ex_imm,
    output logic [31:0]       ex_pc,
    output logic [OP_W-1:0]   ex_op
);

    logic [RS_SZ-1:0]  busy_q, qj_b_q, qk_b_q;
    logic [OP_W-1:0]   op_q  [RS_SZ];
    logic [TAG_W-1:0]  rd_q  [RS_SZ];
    logic [TAG_W-1:0]  qj_q  [RS_SZ];
    logic [TAG_W-1:0]  qk_q  [RS_SZ];
    logic [31:0]       vj_q  [RS_SZ];
    logic [31:0]       vk_q  [RS_SZ];
    logic [31:0]       imm_q [RS_SZ];
    logic [31:0]       pc_q  [RS_SZ];

    logic [RS_SZ-1:0]     hit_aj, hit_lj, hit_ak, hit_lk, ready;
    logic                 free_found, sel_found;
    logic [RS_SZ_LOG-1:0] free_idx, sel_idx;
    logic [31:0]          sel_vj, sel_vk;
    logic                 dis_qj_b, dis_qk_b;
    logic [31:0]          dis_vj, dis_vk;

    assign full = &busy_q;

    always_comb begin
        for (int i = 0; i < int'(RS_SZ); i++) begin
            hit_aj[i] = qj_b_q[i] && tag_hit(cdb_a_vld, cdb_a_tag, qj_q[i]);
            hit_lj[i] = qj_b_q[i] && tag_hit(cdb_l_vld, cdb_l_tag, qj_q[i]);
            hit_ak[i] = qk_b_q[i] && tag_hit(cdb_a_vld, cdb_a_tag, qk_q[i]);
            hit_lk[i] = qk_b_q[i] && tag_hit(cdb_l_vld, cdb_l_tag, qk_q[i]);
`ifdef RS_WAKE_BYPASS_EN
            ready[i]  = busy_q[i] && (!qj_b_q[i] || hit_aj[i] || hit_lj[i])
                                  && (!qk_b_q[i] || hit_ak[i] || hit_lk[i]);
`else
            ready[i]  = busy_q[i] && !qj_b_q[i] && !qk_b_q[i];
`endif
        end
    end

    alu_rs_prio_sel #(
        .N (RS_SZ),
        .W (RS_SZ_LOG)
    ) u_free_sel (
        .req   (~busy_q),
        .found (free_found),
        .idx   (free_idx)
    );

    alu_rs_prio_sel #(
        .N (RS_SZ),
        .W (RS_SZ_LOG)
    ) u_ready_sel (
        .req   (ready),
        .found (sel_found),
        .idx   (sel_idx)
    );

    always_comb begin
        sel_vj = vj_q[sel_idx];
        sel_vk = vk_q[sel_idx];
`ifdef RS_WAKE_BYPASS_EN
        // A still-pending operand can only be selected through a live broadcast; ALU port wins.
        if (qj_b_q[sel_idx]) sel_vj = hit_aj[sel_idx] ? cdb_a_val : cdb_l_val;
        if (qk_b_q[sel_idx]) sel_vk = hit_ak[sel_idx] ? cdb_a_val : cdb_l_val;
`endif
    end

    // Dispatch-time forwarding from either CDB port.
    always_comb begin
        dis_qj_b = iss_qj_b;
        dis_vj   = iss_vj;
        if (iss_qj_b && tag_hit(cdb_a_vld, cdb_a_tag, iss_qj)) begin
            dis_qj_b = 1'b0;
            dis_vj   = cdb_a_val;
        end else if (iss_qj_b && tag_hit(cdb_l_vld, cdb_l_tag, iss_qj)) begin
            dis_qj_b = 1'b0;
            dis_vj   = cdb_l_val;
        end
        dis_qk_b = iss_qk_b;
        dis_vk   = iss_vk;
        if (iss_qk_b && tag_hit(cdb_a_vld, cdb_a_tag, iss_qk)) begin
            dis_qk_b = 1'b0;
            dis_vk   = cdb_a_val;
        end else if (iss_qk_b && tag_hit(cdb_l_vld, cdb_l_tag, iss_qk)) begin
            dis_qk_b = 1'b0;
            dis_vk   = cdb_l_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
            ex_vld <= 1'b0;
            ex_rd  <= '0;
            ex_vj  <= '0;
            ex_vk  <= '0;
            ex_imm <= '0;
            ex_pc  <= '0;
            ex_op  <= '0;
        end else if (rdy) begin
            if (clr) begin
                busy_q <= '0;
                ex_vld <= 1'b0;
            end else begin
                for (int i = 0; i < int'(RS_SZ); i++) begin
                    if (busy_q[i] && (hit_aj[i] || hit_lj[i])) begin
                        vj_q[i]   <= hit_aj[i] ? cdb_a_val : cdb_l_val;
                        qj_b_q[i] <= 1'b0;
                    end
                    if (busy_q[i] && (hit_ak[i] || hit_lk[i])) begin
                        vk_q[i]   <= hit_ak[i] ? cdb_a_val : cdb_l_val;
                        qk_b_q[i] <= 1'b0;
                    end
                end
                // Free slot is never busy, so it cannot collide with wakeup or select.
                if (iss_vld && !full && free_found) begin
                    busy_q[free_idx] <= 1'b1;
                    op_q[free_idx]   <= iss_op;
                    rd_q[free_idx]   <= iss_rd;
                    qj_q[free_idx]   <= iss_qj;
                    qk_q[free_idx]   <= iss_qk;
                    qj_b_q[free_idx] <= dis_qj_b;
                    qk_b_q[free_idx] <= dis_qk_b;
                    vj_q[free_idx]   <= dis_vj;
                    vk_q[free_idx]   <= dis_vk;
                    imm_q[free_idx]  <= iss_imm;
                    pc_q[free_idx]   <= iss_pc;
                end
                if (sel_found) begin
                    busy_q[sel_idx] <= 1'b0;
                    ex_vld <= 1'b1;
                    ex_rd  <= rd_q[sel_idx];
                    ex_vj  <= sel_vj;
                    ex_vk  <= sel_vk;
                    ex_imm <= imm_q[sel_idx];
                    ex_pc  <= pc_q[sel_idx];
                    ex_op  <= op_q[sel_idx];
                end else begin
                    ex_vld <= 1'b0;
                end
            end
        end
    end

endmodule
